// File: rtl/divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// Optional `DIVIDER_EARLY_OUT_EN: skip iterations for divisor 0 or divisor > dividend.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             keep;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] dvd_nx;

    // One restoring step; the sign bit of the trial difference picks the quotient bit
    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        diff    = shifted - {2'b00, dvs_q};
        keep    = ~diff[WIDTH+1];
        rem_nx  = keep ? diff[WIDTH:0] : shifted[WIDTH:0];
        dvd_nx  = {dvd_q[WIDTH-2:0], keep};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef DIVIDER_EARLY_OUT_EN
                    if (divisor == '0 || divisor > dividend) begin
                        quo_d   = (divisor == '0) ? '1 : '0;
                        rmd_d   = dividend;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dvs_d   = divisor;
                        dvd_d   = dividend;
                        rem_d   = '0;
                        cnt_d   = CNT_LAST;
                        state_d = S_BUSY;
                    end
`else
                    dvs_d   = divisor;
                    dvd_d   = dividend;
                    rem_d   = '0;
                    cnt_d   = CNT_LAST;
                    state_d = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                rem_d = rem_nx;
                dvd_d = dvd_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quo_d   = dvd_nx;
                    rmd_d   = rem_nx[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            done_q  <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider: results, latency, done width, robustness.
// Define DIVIDER_EARLY_OUT_EN here too when building the early-out variant.
module tb_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_vec;
    int n_bad;
    logic [31:0] last_q;

    divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er);
        int lat;
        int explat;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        explat = 32;
`ifdef DIVIDER_EARLY_OUT_EN
        if (b == 0 || b > a) explat = 0;
`endif
        lat = -1;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k == 16) chk("busy_hold_q", 64'(quotient), 64'(last_q));
        end
        chk("latency", 64'(lat), 64'(explat));
        chk("quotient", 64'(quotient), 64'(eq));
        chk("remainder", 64'(remainder), 64'(er));
        @(posedge clk); #1;
        chk("done_width", 64'(done), 64'd0);
        last_q = eq;
    endtask

    initial begin
        int cnt;
        bit saw;
        n_vec = 0; n_bad = 0; last_q = 32'd0;
        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_done", 64'(done), 64'd0);

        run_div(32'd10, 32'd7, 32'd1, 32'd3);
        run_div(32'd100, 32'd100, 32'd1, 32'd0);
        run_div(32'd100, 32'd7, 32'd14, 32'd2);
        run_div(32'd100, 32'd0, 32'hFFFFFFFF, 32'd100);
        run_div(32'd70, 32'd150, 32'd0, 32'd70);
        run_div(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0);
        run_div(32'hDEADBEEF, 32'h10000, 32'h0000DEAD, 32'h0000BEEF);

        // Second start mid-division must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 32'd10; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        saw = 1'b0;
        while (cnt < 40 && !saw) begin
            @(negedge clk);
            if (cnt == 5) begin
                start = 1'b1; dividend = 32'd100; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
            if (done === 1'b1) saw = 1'b1;
        end
        chk("restart_latency", 64'(cnt), 64'd32);
        chk("restart_q", 64'(quotient), 64'd1);
        chk("restart_r", 64'(remainder), 64'd3);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a division
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_q", 64'(quotient), 64'd0);
        chk("abort_r", 64'(remainder), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw = 1'b1;
        end
        chk("abort_no_done", 64'(saw), 64'd0);
        last_q = 32'd0;
        run_div(32'd1000, 32'd10, 32'd100, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Sequential unsigned integer divider producing quotient and remainder with a radix-2 restoring algorithm, one quotient bit per clock. It is a standalone arithmetic block with a single-cycle start/done handshake. Callers pulse `start` with the operands and wait for `done`. It trades latency for area and is sized for synthesis and gate-level/SDF-annotated simulation.

## Interface
- `WIDTH`, default 32: operand and result width in bits. The latency figures below assume WIDTH=32.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  when high and the block is IDLE, the operands are captured on this edge.
- `dividend`  in  WIDTH  operand 1, unsigned.
- `divisor`  in  WIDTH  operand 2, unsigned.
- `done`  out  1  one-cycle pulse when the results are valid.
- `quotient`  out  WIDTH  result 1, registered.
- `remainder`  out  WIDTH  result 2, registered.

## Operation
- States:
  - IDLE: waits for `start`.
  - BUSY: performs WIDTH iterations.
  - DONE: pulses `done` for one cycle, then returns to IDLE.
- IDLE -> BUSY on `start`=1:
  - Latch the divisor.
  - Load the shift register with the dividend.
  - Clear the partial remainder (WIDTH+1 bits).
  - Set the iteration counter to WIDTH-1.
- Each BUSY cycle:
  - Shift {partial remainder, dividend register} left by one.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
- After the last iteration: register the final quotient and remainder onto the outputs, assert `done`, and go to DONE.
- DONE -> IDLE unconditionally.
- `start` is ignored in BUSY and DONE. It is not queued, and the operands are not re-sampled.
- Operands may change freely after the capture edge.
- `quotient` and `remainder` hold their last values until the next completion. They do not change during BUSY.
- Divide by zero: no trap. The result falls out of the algorithm: `quotient` = all ones (32'hFFFFFFFF), `remainder` = `dividend`.
- Dividend < divisor: `quotient` = 0, `remainder` = `dividend`.
- Invariant for divisor != 0: dividend = quotient*divisor + remainder, with remainder < divisor.
- Reset:
  - `rst` low at any time, including mid-operation, forces IDLE immediately.
  - `done`=0, `quotient`=0, `remainder`=0; all internal registers are cleared.
  - An aborted division produces no `done`.
  - After `rst` deasserts, the block accepts `start` on the next rising edge.

## Timing
- E0 = the rising edge that samples `start`=1 in IDLE.
- Iterations occupy E1..E32.
- At E32 the outputs are updated and `done` rises. It stays high until E33, when the block re-enters IDLE.
- Latency: results and `done` are visible 32 cycles after E0. A new `start` is accepted at E34 or later, so throughput is one division per 34 cycles.
- `done` is high for exactly one clock period per division.
- A `start` held high for several cycles launches only one division. A `start` still high when the block returns to IDLE launches a new one.

## Configuration
- Macro `DIVIDER_EARLY_OUT_EN`.
- Defined:
  - If the captured divisor is 0, or the divisor is greater than the dividend, skip BUSY.
  - Go IDLE -> DONE at E0, with `quotient` = all ones (divisor 0) or 0, and `remainder` = `dividend`.
  - `done` is high from E0 to E1.
  - All other cases behave as the base design.
- Not defined: every division takes the full latency. Results are identical in both builds; only timing differs.

## Test plan
- Reset low for 2 cycles, then release -> `done`=0, `quotient`=0, `remainder`=0; no activity until `start`.
- 10/7 -> `done` pulse, `quotient`=1, `remainder`=3; then 100/100 -> 1, 0; then 100/7 -> 14, 2. Each `done` arrives exactly 32 cycles after its `start` edge and is one cycle wide.
- 100/0 -> `quotient`=32'hFFFFFFFF, `remainder`=100. With `DIVIDER_EARLY_OUT_EN`, `done` arrives 0 cycles after capture.
- 70/150 -> `quotient`=0, `remainder`=70.
- 32'hFFFFFFFF/1 -> `quotient`=32'hFFFFFFFF, `remainder`=0.
- Robustness:
  - Pulse `start` again mid-division with new operands -> ignored; the original result is still produced.
  - Assert `rst` low at cycle 10 of a division -> no `done`, outputs are 0, and the next division is correct.
